// File: rtl/diff_scoreboard.sv
// Scoreboard for the arithmetic monitor's mismatch stream: counts qualified and
// failing samples, keeps a sticky error mask, captures the first failure, halts after MAX_ERRORS.
module diff_scoreboard #(
    parameter int WIDTH      = 32,
    parameter int CNT_WIDTH  = 32,
    parameter int MAX_ERRORS = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_mon_ready,
    input  logic [WIDTH-1:0]     i_diff,
    input  logic                 i_clear,
    input  logic                 i_snap_req,
    input  logic                 i_snap_ack,
    output logic [1:0]           o_state,
    output logic                 o_halt,
    output logic [CNT_WIDTH-1:0] o_sample_cnt,
    output logic [CNT_WIDTH-1:0] o_error_cnt,
    output logic [WIDTH-1:0]     o_bit_mask,
    output logic [WIDTH-1:0]     o_first_diff,
    output logic [CNT_WIDTH-1:0] o_first_idx,
    output logic                 o_snap_valid,
    output logic [CNT_WIDTH-1:0] o_snap_samples,
    output logic [CNT_WIDTH-1:0] o_snap_errors
);

    typedef enum logic [1:0] {
        WAIT_READY = 2'd0,
        RUN        = 2'd1,
        FAILED     = 2'd2,
        HALTED     = 2'd3
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] MAX_ERR  = CNT_WIDTH'(MAX_ERRORS);
    localparam logic [WIDTH-1:0]     W_ZERO   = {WIDTH{1'b0}};

    state_t                state_q, state_d;
    logic                  halt_q, halt_d;
    logic [CNT_WIDTH-1:0]  sample_cnt_q, sample_cnt_d;
    logic [CNT_WIDTH-1:0]  error_cnt_q, error_cnt_d;
    logic [WIDTH-1:0]      bit_mask_q, bit_mask_d;
    logic [WIDTH-1:0]      first_diff_q, first_diff_d;
    logic [CNT_WIDTH-1:0]  first_idx_q, first_idx_d;
    logic                  snap_valid_q, snap_valid_d;
    logic [CNT_WIDTH-1:0]  snap_samples_q, snap_samples_d;
    logic [CNT_WIDTH-1:0]  snap_errors_q, snap_errors_d;

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        if (v == CNT_MAX) begin
            return v;
        end else begin
            return v + CNT_ONE;
        end
    endfunction

    // Next-state, counter, capture and snapshot logic
    always_comb begin
        state_d        = state_q;
        sample_cnt_d   = sample_cnt_q;
        error_cnt_d    = error_cnt_q;
        bit_mask_d     = bit_mask_q;
        first_diff_d   = first_diff_q;
        first_idx_d    = first_idx_q;
        snap_valid_d   = snap_valid_q;
        snap_samples_d = snap_samples_q;
        snap_errors_d  = snap_errors_q;

        if (i_clear) begin
            state_d        = WAIT_READY;
            sample_cnt_d   = CNT_ZERO;
            error_cnt_d    = CNT_ZERO;
            bit_mask_d     = W_ZERO;
            first_diff_d   = W_ZERO;
            first_idx_d    = CNT_ZERO;
            snap_valid_d   = 1'b0;
            snap_samples_d = CNT_ZERO;
            snap_errors_d  = CNT_ZERO;
        end else begin
            // Snapshot samples the counters as they stand before this edge's update
            if (snap_valid_q) begin
                if (i_snap_ack) begin
                    snap_valid_d = 1'b0;
                end else begin
                    snap_valid_d = 1'b1;
                end
            end else if (i_snap_req) begin
                snap_valid_d   = 1'b1;
                snap_samples_d = sample_cnt_q;
                snap_errors_d  = error_cnt_q;
            end else begin
                snap_valid_d = 1'b0;
            end

            case (state_q)
                WAIT_READY: begin
                    if (i_mon_ready) begin
                        state_d = RUN;
                    end else begin
                        state_d = WAIT_READY;
                    end
                end
                RUN, FAILED: begin
                    if (i_mon_ready) begin
                        sample_cnt_d = sat_inc(sample_cnt_q);
                        if (i_diff != W_ZERO) begin
                            error_cnt_d = sat_inc(error_cnt_q);
                            bit_mask_d  = bit_mask_q | i_diff;
                            if (state_q == RUN) begin
                                first_diff_d = i_diff;
                                first_idx_d  = sample_cnt_q;
                            end else begin
                                first_diff_d = first_diff_q;
                            end
                            if (error_cnt_d == MAX_ERR) begin
                                state_d = HALTED;
                            end else begin
                                state_d = FAILED;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                HALTED: begin
                    state_d = HALTED;
                end
                default: begin
                    state_d = WAIT_READY;
                end
            endcase
        end

        halt_d = (state_d == HALTED);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= WAIT_READY;
            halt_q         <= 1'b0;
            sample_cnt_q   <= CNT_ZERO;
            error_cnt_q    <= CNT_ZERO;
            bit_mask_q     <= W_ZERO;
            first_diff_q   <= W_ZERO;
            first_idx_q    <= CNT_ZERO;
            snap_valid_q   <= 1'b0;
            snap_samples_q <= CNT_ZERO;
            snap_errors_q  <= CNT_ZERO;
        end else begin
            state_q        <= state_d;
            halt_q         <= halt_d;
            sample_cnt_q   <= sample_cnt_d;
            error_cnt_q    <= error_cnt_d;
            bit_mask_q     <= bit_mask_d;
            first_diff_q   <= first_diff_d;
            first_idx_q    <= first_idx_d;
            snap_valid_q   <= snap_valid_d;
            snap_samples_q <= snap_samples_d;
            snap_errors_q  <= snap_errors_d;
        end
    end

    assign o_state        = state_q;
    assign o_halt         = halt_q;
    assign o_sample_cnt   = sample_cnt_q;
    assign o_error_cnt    = error_cnt_q;
    assign o_bit_mask     = bit_mask_q;
    assign o_first_diff   = first_diff_q;
    assign o_first_idx    = first_idx_q;
    assign o_snap_valid   = snap_valid_q;
    assign o_snap_samples = snap_samples_q;
    assign o_snap_errors  = snap_errors_q;

endmodule

// File: tb/tb_diff_scoreboard.sv
// Randomized and directed bench for diff_scoreboard, checked every cycle against
// a behavioural model plus literal expectations at the interesting points.
module tb_diff_scoreboard;

    localparam int W    = 32;
    localparam int CW   = 8;
    localparam int MAXE = 4;
    localparam int SAT  = (1 << CW) - 1;

    logic          clk;
    logic          reset;
    logic          i_mon_ready;
    logic [W-1:0]  i_diff;
    logic          i_clear;
    logic          i_snap_req;
    logic          i_snap_ack;
    logic [1:0]    o_state;
    logic          o_halt;
    logic [CW-1:0] o_sample_cnt;
    logic [CW-1:0] o_error_cnt;
    logic [W-1:0]  o_bit_mask;
    logic [W-1:0]  o_first_diff;
    logic [CW-1:0] o_first_idx;
    logic          o_snap_valid;
    logic [CW-1:0] o_snap_samples;
    logic [CW-1:0] o_snap_errors;

    int checks;
    int failures;

    // Behavioural model state
    int           m_state;
    int           m_samples;
    int           m_errors;
    logic [W-1:0] m_mask;
    logic [W-1:0] m_first_diff;
    int           m_first_idx;
    bit           m_have_first;
    bit           m_snap_valid;
    int           m_snap_s;
    int           m_snap_e;

    diff_scoreboard #(.WIDTH(W), .CNT_WIDTH(CW), .MAX_ERRORS(MAXE)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_mon_ready    (i_mon_ready),
        .i_diff         (i_diff),
        .i_clear        (i_clear),
        .i_snap_req     (i_snap_req),
        .i_snap_ack     (i_snap_ack),
        .o_state        (o_state),
        .o_halt         (o_halt),
        .o_sample_cnt   (o_sample_cnt),
        .o_error_cnt    (o_error_cnt),
        .o_bit_mask     (o_bit_mask),
        .o_first_diff   (o_first_diff),
        .o_first_idx    (o_first_idx),
        .o_snap_valid   (o_snap_valid),
        .o_snap_samples (o_snap_samples),
        .o_snap_errors  (o_snap_errors)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int sat_add1(input int v);
        return (v + 1 > SAT) ? SAT : v + 1;
    endfunction

    // Model: state numbers 0 wait, 1 run, 2 failed, 3 halted
    always @(posedge clk or posedge reset) begin
        if (reset || i_clear) begin
            m_state = 0; m_samples = 0; m_errors = 0; m_mask = '0;
            m_first_diff = '0; m_first_idx = 0; m_have_first = 1'b0;
            m_snap_valid = 1'b0; m_snap_s = 0; m_snap_e = 0;
        end else begin
            if (m_snap_valid) begin
                if (i_snap_ack) m_snap_valid = 1'b0;
            end else if (i_snap_req) begin
                m_snap_valid = 1'b1;
                m_snap_s = m_samples;
                m_snap_e = m_errors;
            end
            if (m_state == 0) begin
                if (i_mon_ready) m_state = 1;
            end else if (m_state != 3 && i_mon_ready) begin
                if (i_diff != 0) begin
                    if (!m_have_first) begin
                        m_have_first = 1'b1;
                        m_first_diff = i_diff;
                        m_first_idx  = m_samples;
                    end
                    m_errors = sat_add1(m_errors);
                    m_mask   = m_mask | i_diff;
                    m_state  = (m_errors == MAXE) ? 3 : 2;
                end
                m_samples = sat_add1(m_samples);
            end
        end
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("m_state",      64'(o_state),        64'(m_state));
        check("m_halt",       64'(o_halt),         64'(m_state == 3));
        check("m_samples",    64'(o_sample_cnt),   64'(m_samples));
        check("m_errors",     64'(o_error_cnt),    64'(m_errors));
        check("m_mask",       64'(o_bit_mask),     64'(m_mask));
        check("m_first_diff", 64'(o_first_diff),   64'(m_first_diff));
        check("m_first_idx",  64'(o_first_idx),    64'(m_first_idx));
        check("m_snap_valid", 64'(o_snap_valid),   64'(m_snap_valid));
        check("m_snap_s",     64'(o_snap_samples), 64'(m_snap_s));
        check("m_snap_e",     64'(o_snap_errors),  64'(m_snap_e));
    endtask

    task automatic check_all_zero(input string nm);
        logic [63:0] all_or;
        all_or = 64'(o_state) | 64'(o_halt) | 64'(o_sample_cnt) | 64'(o_error_cnt)
               | 64'(o_bit_mask) | 64'(o_first_diff) | 64'(o_first_idx)
               | 64'(o_snap_valid) | 64'(o_snap_samples) | 64'(o_snap_errors);
        check(nm, all_or, 64'd0);
    endtask

    // One clock: drive inputs, take the edge, compare at the following negedge
    task automatic cyc(input logic rdy, input logic [W-1:0] d, input logic clr,
                       input logic req, input logic ack);
        i_mon_ready = rdy; i_diff = d; i_clear = clr; i_snap_req = req; i_snap_ack = ack;
        @(posedge clk);
        @(negedge clk);
        if (!reset) compare_model();
    endtask

    initial begin
        checks = 0; failures = 0;
        reset = 1'b1;
        i_mon_ready = 1'b0; i_diff = '0; i_clear = 1'b0; i_snap_req = 1'b0; i_snap_ack = 1'b0;
        #3;
        check_all_zero("reset_zero");
        @(negedge clk);
        reset = 1'b0;
        check("pin_state_wait", 64'(o_state), 64'd0);

        // Ready for 11 edges: one to enter RUN, ten counted clean samples
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("pin_state_run", 64'(o_state), 64'd1);
        for (int i = 0; i < 10; i++) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("pin_samples10", 64'(o_sample_cnt), 64'd10);
        check("pin_errors0",   64'(o_error_cnt),  64'd0);
        check("pin_mask0",     64'(o_bit_mask),   64'd0);

        // First failure after 5 clean samples
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        check("pin_clear_state", 64'(o_state), 64'd0);
        for (int i = 0; i < 6; i++) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 32'h8000_0001, 1'b0, 1'b0, 1'b0);
        check("pin_state_failed", 64'(o_state),      64'd2);
        check("pin_first_idx",    64'(o_first_idx),  64'd5);
        check("pin_first_diff",   64'(o_first_diff), 64'h0000_0100);
        check("pin_mask",         64'(o_bit_mask),   64'h8000_0101);
        check("pin_errors2",      64'(o_error_cnt),  64'd2);

        // Ready low with nonzero diff: nothing counts, state held
        for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0000_00ff, 1'b0, 1'b0, 1'b0);
        check("pin_hold_samples", 64'(o_sample_cnt), 64'd7);
        check("pin_hold_errors",  64'(o_error_cnt),  64'd2);
        check("pin_hold_state",   64'(o_state),      64'd2);

        // Two more failures reach MAX_ERRORS=4 and halt
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        check("pin_halt_early", 64'(o_halt), 64'd0);
        cyc(1'b1, 32'h1, 1'b0, 1'b0, 1'b0);
        check("pin_halt",        64'(o_halt),      64'd1);
        check("pin_state_halt",  64'(o_state),     64'd3);
        check("pin_errors_max",  64'(o_error_cnt), 64'd4);
        for (int i = 0; i < 6; i++) cyc(i[0], W'(i + 1), 1'b0, 1'b0, 1'b0);
        check("pin_frozen_samples", 64'(o_sample_cnt), 64'd9);
        check("pin_frozen_errors",  64'(o_error_cnt),  64'd4);
        check("pin_frozen_first",   64'(o_first_diff), 64'h0000_0100);

        // Clear in HALTED with a concurrent snapshot request
        cyc(1'b1, 32'h1, 1'b1, 1'b1, 1'b0);
        check_all_zero("pin_clear_halted");

        // Snapshot at sample_cnt=7 concurrent with a failing sample
        for (int i = 0; i < 8; i++) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("pin_samples7", 64'(o_sample_cnt), 64'd7);
        cyc(1'b1, 32'h0000_0004, 1'b0, 1'b1, 1'b0);
        check("pin_snap_valid",   64'(o_snap_valid),   64'd1);
        check("pin_snap_samples", 64'(o_snap_samples), 64'd7);
        check("pin_snap_errors",  64'(o_snap_errors),  64'd0);
        check("pin_err_after",    64'(o_error_cnt),    64'd1);
        cyc(1'b1, '0, 1'b0, 1'b1, 1'b0);
        check("pin_snap_ignored", 64'(o_snap_samples), 64'd7);
        cyc(1'b1, '0, 1'b0, 1'b1, 1'b1);
        check("pin_snap_acked", 64'(o_snap_valid), 64'd0);
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("pin_snap_stays_low", 64'(o_snap_valid), 64'd0);

        // Sample counter saturation
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 301; i++) cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);
        check("pin_sample_sat", 64'(o_sample_cnt), 64'(SAT));
        check("pin_sat_state",  64'(o_state),      64'd1);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cyc($urandom_range(0, 3) != 0,
                ($urandom_range(0, 7) == 0) ? W'($urandom) : '0,
                $urandom_range(0, 59) == 0,
                $urandom_range(0, 9) == 0,
                $urandom_range(0, 5) == 0);
        end

        // Asynchronous reset mid-run
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h2, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 check_all_zero("async_reset_zero");
        @(negedge clk);
        reset = 1'b0;
        cyc(1'b1, '0, 1'b0, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
